icache_ctrl: RTL

- Direct-mapped, read-only instruction cache. It serves the fetch side of the CPU and sits between the program counter and the instruction memory.
- It accepts the current PC and returns the 32-bit instruction.
- On a miss it raises BUSYWAIT, which is the PC's HOLD input, and fills a 16-byte block from instruction memory.
- 8 blocks × 4 words; 10-bit instruction address space (1 KB).

---
 rtl/icache_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache, 8 blocks x 4 words, 10-bit fetch address space.
// Latency: zero-cycle hit; a miss costs 1 (detect) + N memory cycles + 1 (update) cycles.
// Backpressure: BUSYWAIT holds the PC for the whole miss; MEM_BUSYWAIT stretches the memory phase.
module icache_ctrl #(
   parameter int INDEX_BITS  = 3,
   parameter int TAG_BITS    = 3,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic [31:0]                    PC,
   output logic [31:0]                    INSTRUCTION,
   output logic                           BUSYWAIT,
   output logic                           MEM_READ,
   output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
   input  logic [BLOCK_WORDS*32-1:0]      MEM_READDATA,
   input  logic                           MEM_BUSYWAIT
);

   localparam int NUM_BLOCKS = 1 << INDEX_BITS;
   localparam int BLOCK_BITS = BLOCK_WORDS * 32;
   localparam int OFF_BITS   = $clog2(BLOCK_WORDS);
   localparam int IDX_LSB    = OFF_BITS + 2;
   localparam int TAG_LSB    = IDX_LSB + INDEX_BITS;
   localparam int ADDR_BITS  = TAG_LSB + TAG_BITS;
   localparam int FA_BITS    = TAG_BITS + INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [FA_BITS-1:0]        fill_addr_q, fill_addr_d;
   logic [BLOCK_BITS-1:0]     fill_data_q, fill_data_d;
   logic [NUM_BLOCKS-1:0]     valid_q;
   logic [TAG_BITS-1:0]       tag_q  [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0]     data_q [NUM_BLOCKS];

   logic [OFF_BITS-1:0]       pc_off;
   logic [INDEX_BITS-1:0]     pc_idx;
   logic [TAG_BITS-1:0]       pc_tag;
   logic [INDEX_BITS-1:0]     fill_idx;
   logic [TAG_BITS-1:0]       fill_tag;
   logic                      hit;
   logic                      unused_pc;

   // Address split; bits above the 1 KB window and the byte offset are not part of the lookup.
   assign pc_off    = PC[2 +: OFF_BITS];
   assign pc_idx    = PC[IDX_LSB +: INDEX_BITS];
   assign pc_tag    = PC[TAG_LSB +: TAG_BITS];
   assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

   assign fill_idx  = fill_addr_q[INDEX_BITS-1:0];
   assign fill_tag  = fill_addr_q[FA_BITS-1:INDEX_BITS];

   assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign INSTRUCTION = data_q[pc_idx][{pc_off, 5'd0} +: 32];
   assign MEM_ADDRESS = fill_addr_q;

   // Next-state and output decode; the fill target is latched so PC motion during a stall is harmless.
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      fill_data_d = fill_data_q;
      BUSYWAIT    = 1'b1;
      MEM_READ    = 1'b0;
      case (state_q)
         S_IDLE: begin
            BUSYWAIT = ~hit;
            if (!hit) begin
               state_d     = S_MEM_READ;
               fill_addr_d = {pc_tag, pc_idx};
            end
         end
         S_MEM_READ: begin
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               fill_data_d = MEM_READDATA;
               state_d     = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, fill address and fill data registers; reset abandons any fill in progress.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         fill_addr_q <= '0;
         fill_data_q <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         fill_data_q <= fill_data_d;
      end
   end

   // Block storage: cleared on reset, written from the fill register in UPDATE (evicts unconditionally).
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (state_q == S_UPDATE) begin
         valid_q[fill_idx] <= 1'b1;
         tag_q[fill_idx]   <= fill_tag;
         data_q[fill_idx]  <= fill_data_q;
      end
   end

endmodule
